// File: rtl/dma_page_addr_latch.sv
// 8237A downstream bus stage: latches A15:A8 from DB on ADSTB, merges with A7:A0 and a
// per-channel page register into the system address, and tracks each DMA bus cycle.
module dma_page_addr_latch #(
    parameter int unsigned PAGE_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [7:0]          DB,
    input  logic                ADSTB,
    input  logic [7:0]          A_LO,
    input  logic                AEN,
    input  logic [3:0]          DACK,
    input  logic                MEMR_N,
    input  logic                MEMW_N,
    input  logic                IOR_N,
    input  logic                IOW_N,
    input  logic                EOP_N,
    input  logic                PG_WR,
    input  logic [1:0]          PG_SEL,
    input  logic [PAGE_W-1:0]   PG_DIN,
    output logic [PAGE_W-1:0]   PG_DOUT,
    output logic [PAGE_W+15:0]  SYS_ADDR,
    output logic                SYS_ADDR_VLD,
    output logic [1:0]          CH,
    output logic [CNT_W-1:0]    XFER_CNT,
    output logic                XFER_DONE,
    output logic                EOP_SEEN,
    output logic                DACK_ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_STROBE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [PAGE_W-1:0] r_page [4];
    logic [7:0]        r_hi_q;
    logic              r_eop_q;

    logic              w_strobe;
    logic              w_dack_ok;
    logic [1:0]        w_ch_enc;

    always_comb begin
        w_strobe  = !MEMR_N || !MEMW_N || !IOR_N || !IOW_N;
        w_dack_ok = 1'b1;
        w_ch_enc  = 2'd0;
        unique case (DACK)
            4'b0001: w_ch_enc = 2'd0;
            4'b0010: w_ch_enc = 2'd1;
            4'b0100: w_ch_enc = 2'd2;
            4'b1000: w_ch_enc = 2'd3;
            default: w_dack_ok = 1'b0;
        endcase
        PG_DOUT = r_page[PG_SEL];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_page[i] <= '0;
            end
            r_hi_q       <= '0;
            r_eop_q      <= 1'b0;
            r_state      <= S_IDLE;
            SYS_ADDR     <= '0;
            SYS_ADDR_VLD <= 1'b0;
            CH           <= '0;
            XFER_CNT     <= '0;
            XFER_DONE    <= 1'b0;
            EOP_SEEN     <= 1'b0;
            DACK_ERR     <= 1'b0;
        end else begin
            if (PG_WR && !AEN) begin
                r_page[PG_SEL] <= PG_DIN;
            end
            if (ADSTB) begin
                r_hi_q <= DB;
            end
            // Page follows live DACK, so mem-to-mem halves each pick up their own page.
            if (AEN && w_dack_ok) begin
                SYS_ADDR <= {r_page[w_ch_enc], r_hi_q, A_LO};
                CH       <= w_ch_enc;
            end
            SYS_ADDR_VLD <= AEN && w_dack_ok && (r_state != S_IDLE);
            XFER_DONE    <= 1'b0;
            EOP_SEEN     <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (AEN) begin
                        r_state  <= S_OWN;
                        XFER_CNT <= '0;
                    end
                end
                S_OWN: begin
                    if (!AEN) begin
                        r_state <= S_IDLE;
                        r_eop_q <= 1'b0;
                    end else if (w_strobe) begin
                        if (w_dack_ok) begin
                            r_state <= S_STROBE;
                        end else begin
                            DACK_ERR <= 1'b1;
                        end
                    end
                end
                S_STROBE: begin
                    if (!AEN) begin
                        r_state <= S_IDLE;
                        r_eop_q <= 1'b0;
                    end else if (!w_strobe) begin
                        // EOP pulse is registered here so it lines up with the DONE cycle.
                        r_state   <= S_DONE;
                        XFER_CNT  <= XFER_CNT + 1'b1;
                        XFER_DONE <= 1'b1;
                        EOP_SEEN  <= r_eop_q || !EOP_N;
                        r_eop_q   <= 1'b0;
                    end else if (!EOP_N) begin
                        r_eop_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_eop_q <= 1'b0;
                    r_state <= AEN ? S_OWN : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
